// File: rtl/rr_mux_n_pkg.sv
// rtl/rr_mux_n_pkg.sv - shared arbitration mode encodings and index-width helper
package rr_mux_n_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Source index width; a 1-bit index is kept even for degenerate channel counts.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot arbiter, round-robin or fixed priority
module rr_arbiter
  import rr_mux_n_pkg::*;
#(
  parameter int N  = 4,
  parameter int RR = MODE_RR,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] base;
  logic [N-1:0]     masked;

  assign base = (RR == MODE_RR) ? ptr : '0;

  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = valid[i] && (SEL_W'(i) >= base);
    end
  end

  // Scan high-to-low so the lowest index wins; masked hits (>= ptr) override the wrap scan.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
      end
    end
    if (|masked) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (masked[i]) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/rr_mux_n.sv
// rtl/rr_mux_n.sv - N-input registered arbitrating mux with valid/ready on both sides
module rr_mux_n
  import rr_mux_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int RR    = MODE_RR,
  localparam int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic             load_en;

  rr_arbiter #(.N(N), .RR(RR)) u_arb (
    .valid     (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign in_ready = rst ? '0 : (grant & {N{load_en}});

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= |in_valid;
      if (|in_valid) begin
        out_data <= sel_data;
        out_src  <= grant_idx;
        // Explicit wrap so non-power-of-two channel counts cycle correctly.
        if (RR == MODE_RR) begin
          ptr <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_n.sv
// tb/tb_rr_mux_n.sv - randomized and directed bench for rr_mux_n against a queue-free scan model
module tb_rr_mux_n;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] in_data_a = '0;
  logic [3:0]   in_valid_a = '0;
  logic         out_ready_a = 1'b1;
  logic [23:0]  in_data_c = '0;
  logic [2:0]   in_valid_c = '0;
  logic         out_ready_c = 1'b1;

  logic [3:0]  a_in_ready, f_in_ready;
  logic [31:0] a_out_data, f_out_data;
  logic [1:0]  a_out_src, f_out_src;
  logic        a_out_valid, f_out_valid;
  logic [2:0]  c_in_ready;
  logic [7:0]  c_out_data;
  logic [1:0]  c_out_src;
  logic        c_out_valid;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int          m_ptr [3] = '{0, 0, 0};
  bit          m_vld [3] = '{0, 0, 0};
  logic [31:0] m_data[3] = '{0, 0, 0};
  int          m_src [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  rr_mux_n #(.WIDTH(32), .N(4), .RR(1)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_src(a_out_src), .out_valid(a_out_valid), .out_ready(out_ready_a));

  rr_mux_n #(.WIDTH(32), .N(4), .RR(0)) u_f (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(f_in_ready),
    .out_data(f_out_data), .out_src(f_out_src), .out_valid(f_out_valid), .out_ready(out_ready_a));

  rr_mux_n #(.WIDTH(8), .N(3), .RR(1)) u_c (
    .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_src(c_out_src), .out_valid(c_out_valid), .out_ready(out_ready_c));

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s inst%0d: got %0h, expected %0h", nm, k, got, exp);
    end
  endtask

  // Cyclic scan starting at the pointer (or at 0 in fixed mode); -1 when nothing is valid.
  function automatic int winner(input logic [3:0] v, input int ptr, input int n, input bit rr);
    int start;
    int c;
    start = rr ? ptr : 0;
    for (int j = 0; j < n; j++) begin
      c = (start + j) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic upd(input int k, input logic [3:0] v, input logic [127:0] d, input int n,
                     input int wd, input bit rr, input bit rdy);
    int w;
    logic [127:0] sh;
    if (rst) begin
      m_vld[k] = 0; m_data[k] = '0; m_src[k] = 0; m_ptr[k] = 0;
    end else if (!m_vld[k] || rdy) begin
      w = winner(v, m_ptr[k], n, rr);
      if (w >= 0) begin
        sh = d >> (w * wd);
        m_vld[k]  = 1;
        m_data[k] = (wd == 8) ? {24'h0, sh[7:0]} : sh[31:0];
        m_src[k]  = w;
        if (rr) m_ptr[k] = (w + 1) % n;
      end else begin
        m_vld[k] = 0;
      end
    end
  endtask

  function automatic logic [3:0] exp_ready(input int k, input logic [3:0] v, input int n,
                                           input bit rr, input bit rdy);
    int w;
    if (rst || !(!m_vld[k] || rdy)) return 4'b0;
    w = winner(v, m_ptr[k], n, rr);
    return (w < 0) ? 4'b0 : 4'(1 << w);
  endfunction

  initial forever begin
    @(posedge clk);
    upd(0, in_valid_a, in_data_a, 4, 32, 1'b1, out_ready_a);
    upd(1, in_valid_a, in_data_a, 4, 32, 1'b0, out_ready_a);
    upd(2, {1'b0, in_valid_c}, {104'h0, in_data_c}, 3, 8, 1'b1, out_ready_c);
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("valid", 0, 32'(a_out_valid), 32'(m_vld[0]));
      chk("valid", 1, 32'(f_out_valid), 32'(m_vld[1]));
      chk("valid", 2, 32'(c_out_valid), 32'(m_vld[2]));
      chk("in_ready", 0, 32'(a_in_ready), 32'(exp_ready(0, in_valid_a, 4, 1'b1, out_ready_a)));
      chk("in_ready", 1, 32'(f_in_ready), 32'(exp_ready(1, in_valid_a, 4, 1'b0, out_ready_a)));
      chk("in_ready", 2, 32'(c_in_ready),
          32'(exp_ready(2, {1'b0, in_valid_c}, 3, 1'b1, out_ready_c)));
      if (m_vld[0]) begin
        chk("data", 0, a_out_data, m_data[0]);
        chk("src", 0, 32'(a_out_src), 32'(m_src[0]));
      end
      if (m_vld[1]) begin
        chk("data", 1, f_out_data, m_data[1]);
        chk("src", 1, 32'(f_out_src), 32'(m_src[1]));
      end
      if (m_vld[2]) begin
        chk("data", 2, 32'(c_out_data), m_data[2]);
        chk("src", 2, 32'(c_out_src), 32'(m_src[2]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid_a = 4'hF;
    in_data_a  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_valid", 0, 32'(a_out_valid), 32'h0);
    chk("rst_data", 0, a_out_data, 32'h0);
    chk("rst_ready", 0, 32'(a_in_ready), 32'h0);
    chk("rst_valid", 2, 32'(c_out_valid), 32'h0);

    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_seq", 0, 32'(a_out_src), 32'(i % 4));
      chk("rr_data", 0, a_out_data, 32'hA000_0000 + 32'(i % 4));
      chk("fixed_seq", 1, 32'(f_out_src), 32'h0);
    end

    out_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_src", 0, 32'(a_out_src), 32'h0);
      chk("stall_data", 0, a_out_data, 32'hA000_0000);
      chk("stall_ready", 0, 32'(a_in_ready), 32'h0);
    end
    out_ready_a = 1'b1;
    tick();
    chk("release_src", 0, 32'(a_out_src), 32'h1);

    in_valid_a = 4'b1010;
    tick(); chk("wrap_a", 0, 32'(a_out_src), 32'h3);
    tick(); chk("wrap_b", 0, 32'(a_out_src), 32'h1);
    tick(); chk("wrap_c", 0, 32'(a_out_src), 32'h3);

    in_valid_a = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("starve", 1, 32'(f_out_src), 32'h0);
      chk("alt", 0, 32'(a_out_src), (i % 2 == 0) ? 32'h0 : 32'h2);
    end

    in_valid_c = 3'b111;
    in_data_c  = {8'h32, 8'h31, 8'h30};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("n3_seq", 2, 32'(c_out_src), 32'(i % 3));
      chk("n3_data", 2, 32'(c_out_data), 32'h30 + 32'(i % 3));
    end
    out_ready_c = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_ready", 2, 32'(c_in_ready), 32'h0);
    tick();
    chk("rst_drop", 2, 32'(c_out_valid), 32'h0);
    chk("rst_drop_data", 2, 32'(c_out_data), 32'h0);
    rst = 1'b0;
    out_ready_c = 1'b1;
    tick();
    chk("restart", 2, 32'(c_out_src), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      in_valid_a  = 4'($urandom);
      in_data_a   = {$urandom, $urandom, $urandom, $urandom};
      out_ready_a = ($urandom_range(0, 3) != 0);
      in_valid_c  = 3'($urandom);
      in_data_c   = 24'($urandom);
      out_ready_c = ($urandom_range(0, 2) != 0);
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
